lap_stopwatch: RTL and testbench

Parametrised BCD stopwatch/countdown timer with lap-hold, preset load and a done pulse. It is the next generation of the board's single-mode stopwatch. It drives a digit bus that the parent feeds straight into `time_multiplexer` and `hex_to_7_segment`. All control inputs are single-cycle pulses from `debouncer` instances in the parent; this block contains no debouncing.

---
 rtl/lap_stopwatch.sv | 183 ++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// BCD stopwatch / countdown timer with lap hold, saturating preset load and done pulse.
// Digit layout: tenths, seconds units, seconds tens (0-5), then minute digits LSD first.
//
// state   | meaning
// PAUSED  | prescaler holds, time register frozen, mode follows mode_i
// RUNNING | prescaler advances, one tick per TICK_CYCLES cycles, mode frozen
module lap_stopwatch #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int MIN_DIGITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic                          load_i,
  input  logic                          lap_i,
  input  logic                          mode_i,
  input  logic [4*(3+MIN_DIGITS)-1:0]   preset_i,
  output logic [4*(3+MIN_DIGITS)-1:0]   digits_o,
  output logic                          running_o,
  output logic                          lap_o,
  output logic                          done_o
);

  localparam int ND = 3 + MIN_DIGITS;
  localparam int W  = 4 * ND;
  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [W-1:0]  ONE      = W'(1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } run_e;

  run_e          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  l_q, l_d;
  logic [W-1:0]  p_q, p_d;
  logic          mode_q, mode_d;
  logic          lap_q, lap_d;
  logic          done_q, done_d;
  logic          running;
  logic          tick;
  logic          load_acc;
  logic [W-1:0]  preset_sat;

  function automatic logic [3:0] lim(input int i);
    return (i == 2) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++)
      if (v[4*i +: 4] > lim(i)) r[4*i +: 4] = lim(i);
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= lim(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = lim(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign running    = (state_q == RUNNING);
  assign tick       = running && (cnt_q == CNT_LAST);
  assign load_acc   = load_i && !running && !clear_i;
  assign preset_sat = bcd_sat(preset_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= PAUSED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    l_d     = l_q;
    p_d     = p_q;
    mode_d  = running ? mode_q : mode_i;
    lap_d   = lap_q;
    done_d  = 1'b0;

    if (running) cnt_d = tick ? '0 : cnt_q + CW'(1);

    if (tick) begin
      if (!mode_q) begin
        t_d = bcd_inc(t_q);
      end else if (t_q == ONE) begin
        t_d     = '0;
        state_d = PAUSED;
        done_d  = 1'b1;
      end else begin
        t_d = bcd_dec(t_q);
      end
    end

    // lap captures the registered value, so a same-cycle tick is not seen
    if (lap_i) begin
      if (running && !lap_q) begin
        l_d   = t_q;
        lap_d = 1'b1;
      end else if (lap_q) begin
        lap_d = 1'b0;
      end
    end

    if (load_acc) begin
      p_d = preset_sat;
      if (mode_i) t_d = preset_sat;
    end else if (start_i) begin
      if (running)                        state_d = PAUSED;
      else if (!(mode_q && t_q == '0))    state_d = RUNNING;
    end

    if (clear_i) begin
      state_d = PAUSED;
      cnt_d   = '0;
      lap_d   = 1'b0;
      done_d  = 1'b0;
      t_d     = mode_q ? p_q : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      t_q    <= '0;
      l_q    <= '0;
      p_q    <= '0;
      mode_q <= 1'b0;
      lap_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      t_q    <= t_d;
      l_q    <= l_d;
      p_q    <= p_d;
      mode_q <= mode_d;
      lap_q  <= lap_d;
      done_q <= done_d;
    end
  end

  assign digits_o  = lap_q ? l_q : t_q;
  assign running_o = running;
  assign lap_o     = lap_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with TICK_CYCLES = 4, MIN_DIGITS = 1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lap_stopwatch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, clear_i, load_i, lap_i, mode_i;
  logic [15:0] preset_i;
  logic [15:0] digits_o;
  logic        running_o, lap_o, done_o;

  int vectors    = 0;
  int miscompares = 0;
  int done_seen  = 0;

  lap_stopwatch #(.TICK_CYCLES(4), .MIN_DIGITS(1)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .clear_i   (clear_i),
    .load_i    (load_i),
    .lap_i     (lap_i),
    .mode_i    (mode_i),
    .preset_i  (preset_i),
    .digits_o  (digits_o),
    .running_o (running_o),
    .lap_o     (lap_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (done_o) done_seen++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic step(input logic s, input logic c, input logic ld, input logic lp);
    start_i = s;
    clear_i = c;
    load_i  = ld;
    lap_i   = lp;
    cyc(1);
    start_i = 1'b0;
    clear_i = 1'b0;
    load_i  = 1'b0;
    lap_i   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    clear_i  = 1'b0;
    load_i   = 1'b0;
    lap_i    = 1'b0;
    mode_i   = 1'b0;
    preset_i = 16'h0000;
    cyc(2);
    chk("rst_digits", 32'(digits_o), 32'h0);
    chk("rst_running", 32'(running_o), 32'h0);
    chk("rst_lap", 32'(lap_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    rst_i = 1'b0;
    cyc(1);

    // up count: first tick 4 cycles after start, 1.0 s after 40, wrap after 6000 ticks
    step(1, 0, 0, 0);
    cyc(3);
    chk("up_pre_tick", 32'(digits_o), 32'h0000);
    cyc(1);
    chk("up_first_tick", 32'(digits_o), 32'h0001);
    cyc(36);
    chk("up_one_sec", 32'(digits_o), 32'h0010);
    cyc(23956);
    chk("up_all_max", 32'(digits_o), 32'h9599);
    chk("up_running", 32'(running_o), 32'h1);
    cyc(4);
    chk("up_wrap", 32'(digits_o), 32'h0000);
    chk("up_no_done", 32'(done_seen), 32'h0);
    step(0, 1, 0, 0);
    chk("clr_digits", 32'(digits_o), 32'h0000);
    chk("clr_running", 32'(running_o), 32'h0);

    // pause after one tick plus 2 cycles, resume completes the partial tick
    step(1, 0, 0, 0);
    cyc(5);
    step(1, 0, 0, 0);
    chk("pause_value", 32'(digits_o), 32'h0001);
    chk("pause_running", 32'(running_o), 32'h0);
    cyc(100);
    chk("pause_hold", 32'(digits_o), 32'h0001);
    step(1, 0, 0, 0);
    chk("resume_running", 32'(running_o), 32'h1);
    cyc(1);
    chk("resume_no_tick", 32'(digits_o), 32'h0001);
    cyc(1);
    chk("resume_tick", 32'(digits_o), 32'h0002);
    step(1, 0, 0, 0);

    // countdown from 1.2 s
    mode_i   = 1'b1;
    preset_i = 16'h0012;
    step(0, 0, 1, 0);
    chk("cd_load", 32'(digits_o), 32'h0012);
    step(0, 1, 0, 0);
    chk("cd_clear_reload", 32'(digits_o), 32'h0012);
    step(1, 0, 0, 0);
    cyc(11);
    chk("cd_two_ticks", 32'(digits_o), 32'h0010);
    cyc(1);
    chk("cd_borrow", 32'(digits_o), 32'h0009);
    cyc(35);
    chk("cd_last", 32'(digits_o), 32'h0001);
    chk("cd_last_running", 32'(running_o), 32'h1);
    chk("cd_last_done", 32'(done_o), 32'h0);
    cyc(1);
    chk("cd_zero", 32'(digits_o), 32'h0000);
    chk("cd_zero_running", 32'(running_o), 32'h0);
    chk("cd_done_high", 32'(done_o), 32'h1);
    cyc(1);
    chk("cd_done_low", 32'(done_o), 32'h0);
    step(1, 0, 0, 0);
    chk("cd_start_ignored", 32'(running_o), 32'h0);
    chk("cd_done_count", 32'(done_seen), 32'h1);

    // saturating preset load, load ignored while running
    preset_i = 16'h1A7F;
    step(0, 0, 1, 0);
    chk("sat_1a7f", 32'(digits_o), 32'h1579);
    preset_i = 16'hA8CB;
    step(0, 0, 1, 0);
    chk("sat_a8cb", 32'(digits_o), 32'h9599);
    step(1, 0, 0, 0);
    chk("sat_run", 32'(running_o), 32'h1);
    preset_i = 16'h0003;
    step(0, 0, 1, 0);
    chk("load_run_ignored", 32'(digits_o), 32'h9599);
    cyc(3);
    chk("cd_minute_borrow_free", 32'(digits_o), 32'h9598);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("preset_kept", 32'(digits_o), 32'h9599);
    chk("preset_kept_running", 32'(running_o), 32'h0);

    // lap freeze, release, capture on a tick edge, clear overriding lap
    mode_i = 1'b0;
    cyc(1);
    step(0, 1, 0, 0);
    chk("lap_clr", 32'(digits_o), 32'h0000);
    step(1, 0, 0, 0);
    cyc(20);
    chk("lap_pre", 32'(digits_o), 32'h0005);
    step(0, 0, 0, 1);
    chk("lap_freeze", 32'(digits_o), 32'h0005);
    chk("lap_flag", 32'(lap_o), 32'h1);
    cyc(9);
    chk("lap_hold", 32'(digits_o), 32'h0005);
    cyc(6);
    step(0, 0, 0, 1);
    chk("lap_release", 32'(digits_o), 32'h0009);
    chk("lap_release_flag", 32'(lap_o), 32'h0);
    cyc(2);
    step(0, 0, 0, 1);
    chk("lap_on_tick", 32'(digits_o), 32'h0009);
    chk("lap_on_tick_flag", 32'(lap_o), 32'h1);
    cyc(4);
    chk("lap_on_tick_hold", 32'(digits_o), 32'h0009);
    step(0, 1, 0, 1);
    chk("lap_clear_flag", 32'(lap_o), 32'h0);
    chk("lap_clear_digits", 32'(digits_o), 32'h0000);
    chk("lap_clear_running", 32'(running_o), 32'h0);

    // priority: clear over start, load over start
    step(1, 0, 0, 0);
    cyc(5);
    chk("prio_pre", 32'(digits_o), 32'h0001);
    step(1, 1, 0, 0);
    chk("prio_clr_running", 32'(running_o), 32'h0);
    chk("prio_clr_digits", 32'(digits_o), 32'h0000);
    preset_i = 16'h0042;
    step(1, 0, 1, 0);
    chk("prio_load_running", 32'(running_o), 32'h0);
    chk("prio_load_digits", 32'(digits_o), 32'h0000);

    // asynchronous reset in the middle of a clock period
    step(1, 0, 0, 0);
    cyc(5);
    step(0, 0, 0, 1);
    chk("arst_pre_lap", 32'(lap_o), 32'h1);
    chk("arst_pre_digits", 32'(digits_o), 32'h0001);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_digits", 32'(digits_o), 32'h0000);
    chk("arst_running", 32'(running_o), 32'h0);
    chk("arst_lap", 32'(lap_o), 32'h0);
    cyc(1);
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
